// File: rtl/mem_param.sv
// mem_param: parameterised register-file memory with asynchronous read.
//
// Holds 2**DEPTH words of WIDTH bits. A write is captured on the rising
// clock edge; the read port is purely combinational, so rdata follows raddr
// with no latency. A synchronous active-low reset clears every word to zero
// and takes priority over a write presented on the same edge.
//
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   rst    - synchronous reset, active-low (0 clears the whole array)
//   write  - write enable, active-high
//   waddr  - write address, DEPTH bits
//   raddr  - read address, DEPTH bits
//   wdata  - write data, WIDTH bits
//   rdata  - read data, WIDTH bits, combinational from raddr
//
// The block is deliberately dumb: no handshake, no flow control and no
// full/empty tracking. The caller gates write.
module mem_param #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [DEPTH-1:0] waddr,
    input  logic [DEPTH-1:0] raddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    // Storage is kept as plain flops / distributed RAM. The whole-array clear
    // and the asynchronous read both rule out a block RAM with a registered
    // output, which is what we want here.
    logic [WIDTH-1:0] mem [2**DEPTH];

    // Reset wins over write: a write offered while rst is low is dropped, and
    // every word is zeroed in a single edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2**DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[waddr] <= wdata;
        end
    end

    // No write-through bypass: a read of the address being written shows the
    // old word until the edge, and the new word right after it.
    assign rdata = mem[raddr];

endmodule

// File: tb/tb_mem_param.sv
// tb_mem_param: directed self-checking bench for mem_param.
//
// Drives a default instance (WIDTH=64, DEPTH=4) and a small instance
// (WIDTH=8, DEPTH=2). Inputs change 1 ns after each rising edge, and reads
// are checked there as well, away from the active edge.
module tb_mem_param;

    logic        clk;
    logic        rst;
    logic        write;
    logic [3:0]  waddr;
    logic [3:0]  raddr;
    logic [63:0] wdata;
    logic [63:0] rdata;

    logic        s_write;
    logic [1:0]  s_waddr;
    logic [1:0]  s_raddr;
    logic [7:0]  s_wdata;
    logic [7:0]  s_rdata;

    int errors = 0;
    int checks = 0;

    mem_param dut (
        .clk   (clk),
        .rst   (rst),
        .write (write),
        .waddr (waddr),
        .raddr (raddr),
        .wdata (wdata),
        .rdata (rdata)
    );

    mem_param #(.WIDTH(8), .DEPTH(2)) dut_small (
        .clk   (clk),
        .rst   (rst),
        .write (s_write),
        .waddr (s_waddr),
        .raddr (s_raddr),
        .wdata (s_wdata),
        .rdata (s_rdata)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one set of inputs to the default instance and let one rising
    // edge take them, leaving time 1 ns past the edge.
    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [3:0] wa, input logic [63:0] wd);
        rst   = r;
        write = w;
        waddr = wa;
        wdata = wd;
        @(posedge clk);
        #1;
    endtask

    // Read the default instance combinationally at a given address.
    task automatic readCheck(input string tag, input logic [3:0] ra,
                             input logic [63:0] exp);
        raddr = ra;
        #1;
        checkOutput(tag, rdata, exp);
    endtask

    initial begin
        rst     = 1'b0;
        write   = 1'b0;
        waddr   = '0;
        raddr   = '0;
        wdata   = '0;
        s_write = 1'b0;
        s_waddr = '0;
        s_raddr = '0;
        s_wdata = '0;

        // Reset for one edge, then release: everything reads zero.
        applyStimulus(1'b0, 1'b0, 4'd0, 64'd0);
        rst = 1'b1;
        readCheck("reset_r0",  4'd0,  64'd0);
        readCheck("reset_r7",  4'd7,  64'd0);
        readCheck("reset_r15", 4'd15, 64'd0);

        // Single write, neighbour untouched.
        applyStimulus(1'b1, 1'b1, 4'd3, 64'hDEADBEEF_00000001);
        write = 1'b0;
        readCheck("wr_a3", 4'd3, 64'hDEADBEEF_00000001);
        readCheck("wr_a4", 4'd4, 64'd0);

        // Fill every address with addr+1 on consecutive edges, then sweep.
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 1'b1, 4'(a), 64'(a + 1));
        end
        write = 1'b0;
        for (int a = 0; a < 16; a++) begin
            readCheck($sformatf("fill_a%0d", a), 4'(a), 64'(a + 1));
        end

        // Read-during-write at the same address: old word before, new after.
        applyStimulus(1'b1, 1'b1, 4'd5, 64'h0A);
        raddr = 4'd5;
        waddr = 4'd5;
        wdata = 64'h55;
        write = 1'b1;
        #1;
        checkOutput("rdw_before", rdata, 64'h0A);
        @(posedge clk);
        #1;
        write = 1'b0;
        checkOutput("rdw_after", rdata, 64'h55);

        // write=0 must not disturb word 2 (still 3 from the fill).
        applyStimulus(1'b1, 1'b0, 4'd2, '1);
        readCheck("nowrite_a2", 4'd2, 64'd3);

        // Reset with write asserted: write discarded, whole array cleared.
        applyStimulus(1'b0, 1'b1, 4'd2, '1);
        rst   = 1'b1;
        write = 1'b0;
        for (int a = 0; a < 16; a++) begin
            readCheck($sformatf("rstclr_a%0d", a), 4'(a), 64'd0);
        end

        // Reset in the middle of a write sequence, then writes resume.
        applyStimulus(1'b1, 1'b1, 4'd0, 64'h11);
        applyStimulus(1'b1, 1'b1, 4'd1, 64'h22);
        applyStimulus(1'b0, 1'b1, 4'd2, 64'h33);
        applyStimulus(1'b1, 1'b1, 4'd3, 64'h99);
        write = 1'b0;
        readCheck("midrst_a0", 4'd0, 64'd0);
        readCheck("midrst_a1", 4'd1, 64'd0);
        readCheck("midrst_a2", 4'd2, 64'd0);
        readCheck("midrst_a3", 4'd3, 64'h99);

        // Small instance: 4 entries, address 3 is the top word.
        s_write = 1'b1;
        s_waddr = 2'd3;
        s_wdata = 8'hA5;
        @(posedge clk);
        #1;
        s_waddr = 2'd0;
        s_wdata = 8'h11;
        @(posedge clk);
        #1;
        s_write = 1'b0;
        s_raddr = 2'd3;
        #1;
        checkOutput("small_a3", 64'(s_rdata), 64'hA5);
        s_raddr = 2'd0;
        #1;
        checkOutput("small_a0", 64'(s_rdata), 64'h11);
        s_raddr = 2'd1;
        #1;
        checkOutput("small_a1", 64'(s_rdata), 64'h00);
        s_raddr = 2'd2;
        #1;
        checkOutput("small_a2", 64'(s_rdata), 64'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
